// File: rtl/wb_queue.sv
// Write-back queue: a circular FIFO of {register, value} writes drained into the register file.
// Optional decode lookup of pending writes is built only when WB_QUEUE_FWD_EN is defined.
module wb_queue #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [D-1:0]               InReg,
  input  logic [W-1:0]               InValue,
  input  logic                       Stall,
  output logic                       WriteReg,
  output logic [D-1:0]               WReg,
  output logic [W-1:0]               WriteValue,
  input  logic [D-1:0]               LookReg,
  output logic                       LookHit,
  output logic [W-1:0]               LookValue,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage is never reset; only the pointers and count define validity.
  logic [D-1:0]  reg_mem [DEPTH];
  logic [W-1:0]  val_mem [DEPTH];

  logic [AW-1:0] head_reg;
  logic [AW-1:0] head_next;
  logic [AW-1:0] tail_reg;
  logic [AW-1:0] tail_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic push;
  logic pop;
  logic empty;

  assign empty   = (count_reg == '0);
  // Fullness is judged on the current count, so a same-cycle pop never makes room.
  assign InReady = (count_reg != CW'(DEPTH));
  assign push    = InValid && InReady;
  assign pop     = !empty && !Stall;

  assign WriteReg   = pop;
  assign WReg       = empty ? '0 : reg_mem[head_reg];
  assign WriteValue = empty ? '0 : val_mem[head_reg];
  assign Count      = count_reg;
  assign Empty      = empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      reg_mem[tail_reg] <= InReg;
      val_mem[tail_reg] <= InValue;
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push) begin
      tail_next = tail_reg + AW'(1);
    end
    if (pop) begin
      head_next = head_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Offsets are in age order from the head, so the last match in the scan is the youngest.
  logic [AW-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match;
  logic          look_hit_next;
  logic [W-1:0]  look_value_next;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_look
      assign slot_idx[gi] = head_reg + AW'(gi);
      assign live[gi]     = (CW'(gi) < count_reg);
      assign match[gi]    = live[gi] && (reg_mem[slot_idx[gi]] == LookReg);
    end
  endgenerate

  always_comb begin
    look_hit_next   = 1'b0;
    look_value_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        look_hit_next   = 1'b1;
        look_value_next = val_mem[slot_idx[k]];
      end
    end
  end

  assign LookHit   = look_hit_next;
  assign LookValue = look_value_next;
`else
  logic unused_look;
  assign unused_look = ^LookReg;
  assign LookHit     = 1'b0;
  assign LookValue   = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, latency, full/stall behaviour, wrap ordering, lookup, async reset.
module tb_wb_queue;

  logic       CLK;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [2:0] InReg;
  logic [7:0] InValue;
  logic       Stall;
  logic       WriteReg;
  logic [2:0] WReg;
  logic [7:0] WriteValue;
  logic [2:0] LookReg;
  logic       LookHit;
  logic [7:0] LookValue;
  logic [2:0] Count;
  logic       Empty;

  int checks = 0;
  int errors = 0;

  wb_queue #(.W(8), .D(3), .DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InValue(InValue), .Stall(Stall), .WriteReg(WriteReg),
    .WReg(WReg), .WriteValue(WriteValue), .LookReg(LookReg), .LookHit(LookHit),
    .LookValue(LookValue), .Count(Count), .Empty(Empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; InReg = '0; InValue = '0; Stall = 1'b0; LookReg = '0;
    repeat (2) tick();
    checks++;
    if (WriteReg !== 1'b0 || WReg !== 3'd0 || WriteValue !== 8'd0 || InReady !== 1'b1 ||
        Empty !== 1'b1 || Count !== 3'd0 || LookHit !== 1'b0 || LookValue !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: wr=%b wreg=%0d wval=%h rdy=%b empty=%b cnt=%0d hit=%b lv=%h required 0 0 00 1 1 0 0 00",
               WriteReg, WReg, WriteValue, InReady, Empty, Count, LookHit, LookValue);
    end
    Reset = 1'b0;
    tick();
    $display("test_reset: checked outputs during reset");
  endtask

  task automatic test_single();
    InValid = 1'b1; InReg = 3'd3; InValue = 8'hFE; Stall = 1'b0;
    #1;
    checks++;
    if (WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: WriteReg=%b required 0", WriteReg);
    end
    tick();
    InValid = 1'b0;
    #1;
    checks++;
    if (WriteReg !== 1'b1 || WReg !== 3'd3 || WriteValue !== 8'hFE || Count !== 3'd1) begin
      errors++;
      $display("FAIL single_write: wr=%b wreg=%0d wval=%h cnt=%0d required 1 3 fe 1",
               WriteReg, WReg, WriteValue, Count);
    end
    tick();
    checks++;
    if (Empty !== 1'b1 || WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: empty=%b wr=%b required 1 0", Empty, WriteReg);
    end
    $display("test_single: push {3,fe} wr=%b", WriteReg);
  endtask

  task automatic fill4(input logic [2:0] base);
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1;
      InReg   = base + 3'(i);
      InValue = 8'(({5'd0, base} + 8'(i)) * 8'h11);
      tick();
    end
    InValid = 1'b0;
    #1;
  endtask

  task automatic test_full_stall();
    fill4(3'd1);
    checks++;
    if (Count !== 3'd4 || InReady !== 1'b0 || WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL full_count: cnt=%0d rdy=%b wr=%b required 4 0 0", Count, InReady, WriteReg);
    end
    InValid = 1'b1; InReg = 3'd5; InValue = 8'h55;
    tick();
    InValid = 1'b0;
    checks++;
    if (Count !== 3'd4) begin
      errors++;
      $display("FAIL full_ignore: cnt=%0d required 4", Count);
    end
    Stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (WriteReg !== 1'b1 || WReg !== 3'(k) || WriteValue !== 8'(k * 17)) begin
        errors++;
        $display("FAIL drain_order: k=%0d wr=%b wreg=%0d wval=%h required 1 %0d %h",
                 k, WriteReg, WReg, WriteValue, k, 8'(k * 17));
      end
      tick();
    end
    checks++;
    if (Empty !== 1'b1) begin
      errors++;
      $display("FAIL full_drained: empty=%b required 1 (fifth push must not appear)", Empty);
    end
    $display("test_full_stall: drained 4 entries");
  endtask

  task automatic test_push_on_pop();
    logic [2:0] exp_reg [4];
    fill4(3'd2);
    Stall = 1'b0;
    InValid = 1'b1; InReg = 3'd6; InValue = 8'h66;
    #1;
    checks++;
    if (InReady !== 1'b0 || WriteReg !== 1'b1) begin
      errors++;
      $display("FAIL pop_no_room: rdy=%b wr=%b required 0 1", InReady, WriteReg);
    end
    tick();
    checks++;
    if (Count !== 3'd3 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reject_then_ready: cnt=%0d rdy=%b required 3 1", Count, InReady);
    end
    tick();
    InValid = 1'b0;
    checks++;
    if (Count !== 3'd3) begin
      errors++;
      $display("FAIL push_pop_same: cnt=%0d required 3", Count);
    end
    exp_reg[0] = 3'd4; exp_reg[1] = 3'd5; exp_reg[2] = 3'd6; exp_reg[3] = 3'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (WriteReg !== 1'b1 || WReg !== exp_reg[k] || Count > 3'd4) begin
        errors++;
        $display("FAIL push_on_pop_order: k=%0d wr=%b wreg=%0d cnt=%0d required 1 %0d",
                 k, WriteReg, WReg, Count, exp_reg[k]);
      end
      tick();
    end
    checks++;
    if (Empty !== 1'b1) begin
      errors++;
      $display("FAIL push_on_pop_end: empty=%b required 1", Empty);
    end
    $display("test_push_on_pop: late push accepted once");
  endtask

  task automatic test_lookup();
    Stall = 1'b1;
    InValid = 1'b1; InReg = 3'd6; InValue = 8'hAA; tick();
    InReg = 3'd6; InValue = 8'hBB; tick();
    InValid = 1'b0;
    LookReg = 3'd6;
    #1;
`ifdef WB_QUEUE_FWD_EN
    checks++;
    if (LookHit !== 1'b1 || LookValue !== 8'hBB) begin
      errors++;
      $display("FAIL look_youngest: hit=%b val=%h required 1 bb", LookHit, LookValue);
    end
    LookReg = 3'd7;
    #1;
    checks++;
    if (LookHit !== 1'b0 || LookValue !== 8'h00) begin
      errors++;
      $display("FAIL look_miss: hit=%b val=%h required 0 00", LookHit, LookValue);
    end
`else
    checks++;
    if (LookHit !== 1'b0 || LookValue !== 8'h00) begin
      errors++;
      $display("FAIL look_disabled: hit=%b val=%h required 0 00", LookHit, LookValue);
    end
`endif
    Stall = 1'b0;
    LookReg = 3'd0;
    #1;
    checks++;
    if (WReg !== 3'd6 || WriteValue !== 8'hAA) begin
      errors++;
      $display("FAIL look_drain_first: wreg=%0d wval=%h required 6 aa", WReg, WriteValue);
    end
    repeat (2) tick();
    checks++;
    if (Empty !== 1'b1) begin
      errors++;
      $display("FAIL look_drained: empty=%b required 1", Empty);
    end
    $display("test_lookup: two writes to r6");
  endtask

  task automatic test_wrap();
    logic [2:0] exp_reg [6];
    logic [7:0] exp_val [6];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    for (int i = 0; i < 6; i++) begin
      exp_reg[i] = 3'(i + 2);
      exp_val[i] = 8'hA0 + 8'(i);
    end
    while ((pushed < 6 || popped < 6) && cyc < 60) begin
      Stall   = (cyc % 3) != 2;
      InValid = (pushed < 6);
      InReg   = (pushed < 6) ? exp_reg[pushed] : 3'd0;
      InValue = (pushed < 6) ? exp_val[pushed] : 8'd0;
      #1;
      if (WriteReg === 1'b1) begin
        checks++;
        if (popped >= 6 || WReg !== exp_reg[popped] || WriteValue !== exp_val[popped]) begin
          errors++;
          $display("FAIL wrap_order: idx=%0d wreg=%0d wval=%h", popped, WReg, WriteValue);
        end
        popped++;
      end
      if (InValid && InReady) pushed++;
      tick();
      cyc++;
    end
    InValid = 1'b0; Stall = 1'b0;
    checks++;
    if (popped != 6 || Empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_timeout: popped=%0d empty=%b required 6 1", popped, Empty);
    end
    $display("test_wrap: %0d pushed %0d popped in %0d cycles", pushed, popped, cyc);
  endtask

  task automatic test_async_reset();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InReg = 3'(i + 1); InValue = 8'h30 + 8'(i);
      tick();
    end
    InValid = 1'b0;
    Stall = 1'b0;
    #1;
    checks++;
    if (Count !== 3'd3 || WriteReg !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_count: cnt=%0d wr=%b required 3 1", Count, WriteReg);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (Count !== 3'd0 || WriteReg !== 1'b0 || InReady !== 1'b1 || Empty !== 1'b1 ||
        WReg !== 3'd0 || WriteValue !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d wr=%b rdy=%b empty=%b wreg=%0d wval=%h required 0 0 1 1 0 00",
               Count, WriteReg, InReady, Empty, WReg, WriteValue);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (Empty !== 1'b1 || WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: empty=%b wr=%b required 1 0", Empty, WriteReg);
    end
    $display("test_async_reset: mid-drain reset cleared queue");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_push_on_pop();
    test_lookup();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL take parameters: W, default 8, data width; D, default 3, register address width; DEPTH, default 4, entry count (power of two, at least 2).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port InValid, input, 1, execute stage offers a register write.
REQ-005 The block SHALL have port InReady, output, 1, queue can accept an entry this cycle.
REQ-006 The block SHALL have port InReg, input, D, destination register of the offered write.
REQ-007 The block SHALL have port InValue, input, W, data of the offered write.
REQ-008 The block SHALL have port Stall, input, 1, register file write port unavailable this cycle.
REQ-009 The block SHALL have port WriteReg, output, 1, register file write enable.
REQ-010 The block SHALL have port WReg, output, D, register file write address.
REQ-011 The block SHALL have port WriteValue, output, W, register file write data.
REQ-012 The block SHALL have port LookReg, input, D, register being read by decode.
REQ-013 The block SHALL have port LookHit, output, 1, a queued write to LookReg is pending.
REQ-014 The block SHALL have port LookValue, output, W, data of the youngest pending write to LookReg.
REQ-015 The block SHALL have port Count, output, $clog2(DEPTH)+1, number of queued entries.
REQ-016 The block SHALL have port Empty, output, 1, Count equals 0.

Function
REQ-017 The queue SHALL be a circular FIFO of DEPTH {reg, value} entries with head and tail pointers that wrap from DEPTH-1 to 0.
REQ-018 InReady SHALL equal (Count != DEPTH); a pop in the same cycle does not free space for a push when the queue is full.
REQ-019 A push SHALL occur on a rising edge with InValid=1 and InReady=1; {InReg, InValue} is stored at tail and tail advances.
REQ-020 WriteReg SHALL equal (!Empty && !Stall), combinational; WReg and WriteValue SHALL present the head entry, and 0 when Empty.
REQ-021 A pop SHALL occur on every rising edge with WriteReg=1; head advances.
REQ-022 An accepted entry SHALL first appear on WriteReg/WReg/WriteValue the cycle after acceptance (latency 1), with no bypass.
REQ-023 Simultaneous push and pop SHALL leave Count unchanged; push only increments it, pop only decrements it.
REQ-024 Entries SHALL drain strictly in acceptance order; multiple entries to the same register are all written, in order.
REQ-025 InValid while full SHALL be ignored; the offering stage holds its request.
REQ-026 Stall=1 SHALL hold the head entry and all state unchanged except for pushes.

Reset
REQ-027 Reset=1 SHALL immediately, independent of CLK, clear the head, tail and Count to 0 and discard all pending entries.
REQ-028 During and after reset, outputs SHALL be: WriteReg 0, WReg 0, WriteValue 0, InReady 1, Empty 1, Count 0, LookHit 0, LookValue 0.
REQ-029 Entry storage contents SHALL NOT require a reset.

Configuration
REQ-030 Macro WB_QUEUE_FWD_EN, when defined, SHALL enable the lookup: LookHit=1 when any queued entry, including the head, matches LookReg; LookValue is then the value of the youngest matching entry, and 0 when there is no match; both are combinational.
REQ-031 When WB_QUEUE_FWD_EN is undefined, LookHit and LookValue SHALL be tied to 0, LookReg SHALL be ignored, and no compare logic SHALL be built.

Verification
REQ-032 Reset, then push {3, 0xFE} with Stall=0 -> next cycle WriteReg=1, WReg=3, WriteValue=0xFE, Count=1; the following cycle Empty=1.
REQ-033 Stall=1, push {1,0x11},{2,0x22},{3,0x33},{4,0x44} -> Count=4, InReady=0; a fifth push {5,0x55} is ignored; release Stall -> writes 1,2,3,4 on four consecutive cycles.
REQ-034 Stall=1 with the queue full, push offered during a pop cycle after Stall drops -> push rejected that cycle, accepted next cycle; Count never exceeds 4.
REQ-035 With WB_QUEUE_FWD_EN defined, Stall=1, push {6,0xAA} then {6,0xBB}, LookReg=6 -> LookHit=1, LookValue=0xBB; LookReg=7 -> LookHit=0, LookValue=0.
REQ-036 Push 6 entries while Stall toggles so the pointers wrap -> output order matches input order exactly.
REQ-037 Assert Reset mid-drain with Count=3 -> Count=0, WriteReg=0 and InReady=1 immediately, before the next CLK edge.
